// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - maze geometry, score codes and tracker state encoding
package pacman_pkg;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE
  } state_t;

  localparam logic [1:0] SEL_PELLET = 2'b00;
  localparam logic [1:0] SEL_POWER  = 2'b01;
  localparam logic [1:0] SEL_FRUIT  = 2'b10;
  localparam logic [1:0] SEL_GHOST  = 2'b11;

  localparam logic [4:0] FRUIT_X_DEF = 5'd11;
  localparam logic [3:0] FRUIT_Y_DEF = 4'd6;

  // Column x lives in bit 23-x of its row; 1 = wall.
  localparam logic [23:0] MAZE_WALL [0:13] = '{
    24'hFFFFFF, 24'h800001, 24'h800001, 24'h8C3C31, 24'h800001,
    24'h8C0031, 24'h800001, 24'h8C0031, 24'h800001, 24'h8C3C31,
    24'h800001, 24'h800001, 24'h800001, 24'hFFFFFF
  };

  localparam cell_t POWER_CELLS [0:3] = '{
    '{x: 5'd1,  y: 4'd2},  '{x: 5'd22, y: 4'd2},
    '{x: 5'd1,  y: 4'd12}, '{x: 5'd22, y: 4'd12}
  };

  function automatic logic is_power(input logic [4:0] x, input logic [3:0] y);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (POWER_CELLS[i].x == x && POWER_CELLS[i].y == y) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [23:0] initial_row(input logic [3:0] y, input logic [4:0] fx,
                                              input logic [3:0] fy);
    logic [23:0] r;
    r = ~MAZE_WALL[y];
    if (y == fy && fx <= 5'd23) r[5'd23 - fx] = 1'b0;
    return r;
  endfunction

  function automatic logic [8:0] initial_count(input logic [4:0] fx, input logic [3:0] fy);
    logic [8:0] n;
    n = '0;
    for (int y = 0; y < 14; y++) n = n + 9'($countones(initial_row(4'(y), fx, fy)));
    return n;
  endfunction

  localparam logic [8:0] PELLET_COUNT = initial_count(FRUIT_X_DEF, FRUIT_Y_DEF);

endpackage

// File: rtl/fright_timer.sv
// rtl/fright_timer.sv - frightened-mode countdown; a load always beats expiry
module fright_timer #(
  parameter logic [23:0] CYCLES = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  output logic active
);

  logic [23:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= CYCLES;
      active <= (CYCLES != 24'd0);
    end else if (clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (active) begin
      count  <= count - 24'd1;
      active <= (count != 24'd1);
    end
  end

endmodule

// File: rtl/pellet_tracker.sv
// rtl/pellet_tracker.sv - pellet bitmap, move scoring and ghost arbitration
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter logic [23:0] FRIGHT_CYCLES = 24'd10_000_000,
  parameter logic [4:0]  FRUIT_X       = 5'd11,
  parameter logic [3:0]  FRUIT_Y       = 4'd6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [4:0] pac_x,
  input  logic [3:0] pac_y,
  input  logic       ghost_hit,
  input  logic       fruit_avail,
  input  logic       level_restart,
  output logic       score_en,
  output logic [1:0] score_sel,
  output logic       fruit_taken,
  output logic       frightened,
  output logic       pacman_dead,
  output logic [8:0] pellets_left,
  output logic       level_clear
);

  localparam logic [8:0] INIT_COUNT = (FRUIT_X == FRUIT_X_DEF && FRUIT_Y == FRUIT_Y_DEF) ?
                                      PELLET_COUNT : initial_count(FRUIT_X, FRUIT_Y);

  state_t      state;
  logic [23:0] pellet_map [0:13];
  logic [4:0]  cur_x;
  logic [3:0]  cur_y;
  logic        ghost_pend;

  logic        in_range, has_pellet, on_power, on_fruit;
  logic        move_emit, restart, ghost_evt, tmr_load, tmr_clear;
  logic [23:0] cur_row;

  // The lookup cycle commits the update so its outputs are visible during UPDATE.
  always_comb begin
    in_range   = (cur_x <= 5'd23) && (cur_y <= 4'd13);
    cur_row    = in_range ? pellet_map[cur_y] : '0;
    has_pellet = in_range && cur_row[5'd23 - cur_x];
    on_power   = is_power(cur_x, cur_y);
    on_fruit   = in_range && cur_x == FRUIT_X && cur_y == FRUIT_Y && fruit_avail;
    move_emit  = (state == ST_LOOKUP) && (has_pellet || on_fruit);
    restart    = (state == ST_IDLE) && level_restart;
    ghost_evt  = ghost_pend || ghost_hit;
    tmr_load   = (state == ST_LOOKUP) && has_pellet && on_power;
    tmr_clear  = restart;
  end

  fright_timer #(.CYCLES(FRIGHT_CYCLES)) u_fright_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .clear   (tmr_clear),
    .active  (frightened)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      move_ready   <= 1'b1;
      cur_x        <= '0;
      cur_y        <= '0;
      ghost_pend   <= 1'b0;
      score_en     <= 1'b0;
      score_sel    <= SEL_PELLET;
      fruit_taken  <= 1'b0;
      pacman_dead  <= 1'b0;
      level_clear  <= 1'b0;
      pellets_left <= INIT_COUNT;
      for (int y = 0; y < 14; y++) pellet_map[y] <= initial_row(4'(y), FRUIT_X, FRUIT_Y);
    end else begin
      score_en    <= 1'b0;
      score_sel   <= SEL_PELLET;
      fruit_taken <= 1'b0;
      pacman_dead <= 1'b0;
      level_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (restart) begin
            pellets_left <= INIT_COUNT;
            for (int y = 0; y < 14; y++) pellet_map[y] <= initial_row(4'(y), FRUIT_X, FRUIT_Y);
          end else if (move_valid) begin
            cur_x      <= pac_x;
            cur_y      <= pac_y;
            state      <= ST_LOOKUP;
            move_ready <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          state <= ST_UPDATE;
          if (has_pellet) begin
            pellet_map[cur_y][5'd23 - cur_x] <= 1'b0;
            pellets_left <= (pellets_left != 9'd0) ? pellets_left - 9'd1 : 9'd0;
            level_clear  <= (pellets_left == 9'd1);
            score_en     <= 1'b1;
            score_sel    <= on_power ? SEL_POWER : SEL_PELLET;
          end else if (on_fruit) begin
            score_en    <= 1'b1;
            score_sel   <= SEL_FRUIT;
            fruit_taken <= 1'b1;
          end
        end
        ST_UPDATE: begin
          state      <= ST_IDLE;
          move_ready <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          move_ready <= 1'b1;
        end
      endcase
      // A move score owns the cycle; a hit arriving while one is pending merges into it.
      if (restart) begin
        ghost_pend <= 1'b0;
      end else if (ghost_evt && !move_emit) begin
        ghost_pend <= 1'b0;
        if (frightened) begin
          score_en  <= 1'b1;
          score_sel <= SEL_GHOST;
        end else begin
          pacman_dead <= 1'b1;
        end
      end else if (ghost_hit) begin
        ghost_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pellet_tracker.sv
// tb/tb_pellet_tracker.sv - scoreboard bench for pellet_tracker
module tb_pellet_tracker;
  import pacman_pkg::*;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       move_valid = 1'b0, ghost_hit = 1'b0, fruit_avail = 1'b0, level_restart = 1'b0;
  logic [4:0] pac_x = '0;
  logic [3:0] pac_y = '0;
  logic       move_ready, score_en, fruit_taken, frightened, pacman_dead, level_clear;
  logic [1:0] score_sel;
  logic [8:0] pellets_left;

  pellet_tracker #(.FRIGHT_CYCLES(24'd20), .FRUIT_X(5'd11), .FRUIT_Y(4'd6)) dut (
    .clk(clk), .reset_n(reset_n), .move_valid(move_valid), .move_ready(move_ready),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_hit(ghost_hit), .fruit_avail(fruit_avail),
    .level_restart(level_restart), .score_en(score_en), .score_sel(score_sel),
    .fruit_taken(fruit_taken), .frightened(frightened), .pacman_dead(pacman_dead),
    .pellets_left(pellets_left), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       en;
    logic [1:0] sel;
    logic       dead;
    logic       fruit;
    logic       clr;
    logic [8:0] left;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   n_tests = 0, n_fail = 0, cyc = 0, init_left = 0, left = 0;
  bit   monitor_on = 1'b0;
  bit   model [0:13][0:23];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (monitor_on && reset_n === 1'b1) begin
      n_tests++;
      if (score_en !== 1'b1 && score_sel !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_sel: cyc=%0d score_sel=%b required 00", cyc, score_sel);
      end
      if (score_en === 1'b1 || pacman_dead === 1'b1 || fruit_taken === 1'b1 || level_clear === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cyc=%0d en=%b sel=%b dead=%b fruit=%b clear=%b, required no event",
                   cyc, score_en, score_sel, pacman_dead, fruit_taken, level_clear);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc != mon_e.cyc || score_en !== mon_e.en || score_sel !== mon_e.sel ||
              pacman_dead !== mon_e.dead || fruit_taken !== mon_e.fruit ||
              level_clear !== mon_e.clr || pellets_left !== mon_e.left) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d en=%b sel=%b dead=%b fruit=%b clear=%b left=%0d, required cyc=%0d en=%b sel=%b dead=%b fruit=%b clear=%b left=%0d",
                     cyc, score_en, score_sel, pacman_dead, fruit_taken, level_clear, pellets_left,
                     mon_e.cyc, mon_e.en, mon_e.sel, mon_e.dead, mon_e.fruit, mon_e.clr, mon_e.left);
          end
        end
      end
    end
  end

  function automatic bit is_pow(input int x, input int y);
    return (x == 1 || x == 22) && (y == 2 || y == 12);
  endfunction

  function automatic void push_ev(input int c, input logic en, input logic [1:0] sel,
                                  input logic dead, input logic fr, input logic clr, input int l);
    ev_t e;
    e.cyc = c; e.en = en; e.sel = sel; e.dead = dead; e.fruit = fr; e.clr = clr; e.left = 9'(l);
    exp_q.push_back(e);
  endfunction

  task automatic load_model();
    logic [23:0] row;
    left = 0;
    for (int y = 0; y < 14; y++) begin
      row = MAZE_WALL[y];
      for (int x = 0; x < 24; x++) begin
        model[y][x] = !row[23 - x] && !(x == 11 && y == 6);
        if (model[y][x]) left++;
      end
    end
  endtask

  task automatic start_move(input int x, input int y, output int c);
    int w;
    w = 0;
    while (move_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (move_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL move_ready_wait: move_ready=%b required 1", move_ready);
    end
    pac_x = 5'(x); pac_y = 4'(y); move_valid = 1'b1; c = cyc;
    if (x < 24 && y < 14 && model[y][x]) begin
      model[y][x] = 1'b0;
      left--;
      push_ev(c + 2, 1'b1, is_pow(x, y) ? 2'b01 : 2'b00, 1'b0, 1'b0, left == 0, left);
    end else if (fruit_avail && x == 11 && y == 6) begin
      push_ev(c + 2, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, left);
    end
  endtask

  task automatic do_move(input int x, input int y);
    int c;
    start_move(x, y, c);
    @(posedge clk); #1;
    move_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (move_ready !== 1'b1 || pellets_left !== 9'(init_left)) begin
      n_fail++;
      $display("FAIL reset_state: move_ready=%b left=%0d, required 1 and %0d", move_ready, pellets_left, init_left);
    end
    n_tests++;
    if ({score_en, score_sel, fruit_taken, frightened, pacman_dead, level_clear} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b sel=%b fruit=%b fr=%b dead=%b clear=%b, required all 0",
               score_en, score_sel, fruit_taken, frightened, pacman_dead, level_clear);
    end
  endtask

  task automatic test_pellet();
    int c;
    start_move(2, 2, c);
    @(posedge clk); #1;
    move_valid = 1'b0;
    n_tests++;
    if (move_ready !== 1'b0) begin n_fail++; $display("FAIL ready_busy: move_ready=%b required 0", move_ready); end
    @(posedge clk); #1;
    n_tests++;
    if (pellets_left !== 9'(init_left - 1)) begin
      n_fail++; $display("FAIL pellet_count: left=%0d required %0d", pellets_left, init_left - 1);
    end
    @(posedge clk); #1;
    n_tests++;
    if (move_ready !== 1'b1) begin n_fail++; $display("FAIL ready_back: move_ready=%b required 1", move_ready); end
    do_move(2, 2);
    n_tests++;
    if (pellets_left !== 9'(left)) begin n_fail++; $display("FAIL repeat_cell: left=%0d required %0d", pellets_left, left); end
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pellet_pending: %0d events outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_no_event();
    do_move(0, 1);
    do_move(24, 0);
    do_move(7, 15);
    n_tests++;
    if (pellets_left !== 9'(left)) begin n_fail++; $display("FAIL no_event_count: left=%0d required %0d", pellets_left, left); end
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL no_event_pending: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_power_ghost();
    int c, g;
    bit exp_fr;
    start_move(1, 2, c);
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk); #1;
      move_valid = 1'b0;
      ghost_hit = (k == 5);
      if (k == 5) push_ev(c + 6, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, left);
      exp_fr = (k >= 2 && k <= 21);
      n_tests++;
      if (frightened !== exp_fr) begin
        n_fail++; $display("FAIL frightened_window: k=%0d frightened=%b required %b", k, frightened, exp_fr);
      end
    end
    ghost_hit = 1'b1; g = cyc;
    push_ev(g + 1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, left);
    @(posedge clk); #1;
    ghost_hit = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL power_pending: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_fruit();
    fruit_avail = 1'b1;
    do_move(11, 6);
    fruit_avail = 1'b0;
    do_move(11, 6);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fruit_pending: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_ghost_collision();
    int c;
    do_move(1, 12);
    start_move(3, 2, c);
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    ghost_hit = 1'b1;
    push_ev(c + 3, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, left);
    @(posedge clk); #1;
    ghost_hit = 1'b0;
    // Two hits around a scoring move collapse into one ghost event.
    start_move(4, 2, c);
    @(posedge clk); #1;
    move_valid = 1'b0; ghost_hit = 1'b1;
    push_ev(c + 3, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, left);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ghost_hit = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL collision_pending: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_level_clear();
    for (int y = 0; y < 14; y++)
      for (int x = 0; x < 24; x++)
        if (model[y][x]) do_move(x, y);
    n_tests++;
    if (pellets_left !== 9'd0) begin n_fail++; $display("FAIL cleared_count: left=%0d required 0", pellets_left); end
    do_move(2, 2);
    n_tests++;
    if (pellets_left !== 9'd0) begin n_fail++; $display("FAIL saturate: left=%0d required 0", pellets_left); end
    n_tests++;
    if (frightened !== 1'b1) begin n_fail++; $display("FAIL last_power: frightened=%b required 1", frightened); end
    level_restart = 1'b1; move_valid = 1'b1; ghost_hit = 1'b1; pac_x = 5'd5; pac_y = 4'd2;
    @(posedge clk); #1;
    level_restart = 1'b0; move_valid = 1'b0; ghost_hit = 1'b0;
    load_model();
    n_tests++;
    if (move_ready !== 1'b1 || pellets_left !== 9'(init_left) || frightened !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: ready=%b left=%0d fr=%b, required 1 %0d 0", move_ready, pellets_left, frightened, init_left);
    end
    do_move(5, 2);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_pending: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    pac_x = 5'd3; pac_y = 4'd2; move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    load_model();
    n_tests++;
    if (move_ready !== 1'b1 || pellets_left !== 9'(init_left) || frightened !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b left=%0d fr=%b, required 1 %0d 0", move_ready, pellets_left, frightened, init_left);
    end
    do_move(3, 2);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL reset_mid_pending: %0d outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    load_model();
    init_left = left;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    monitor_on = 1'b1;
    test_reset();
    test_pellet();
    test_no_event();
    test_power_ghost();
    test_fruit();
    test_ghost_collision();
    test_level_clear();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
